// File: rtl/brick_pkg.sv
// Shared definitions for the brick row block.
// Holds the row controller state encoding and the default geometry used
// by the interface, the top level and the overlap detector.
package brick_pkg;

  typedef enum logic [1:0] {
    CHECK   = 2'd0,
    RESOLVE = 2'd1,
    MOVE    = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int DEF_N_BRICKS    = 8;
  localparam int DEF_COORD_W     = 10;
  localparam int DEF_BRICK_W     = 57;
  localparam int DEF_BRICK_H     = 19;
  localparam int DEF_BRICK_PITCH = 64;
  localparam int DEF_BALL_SIZE   = 20;
  localparam int DEF_FLOOR_Y     = 458;
  localparam int DEF_SPEED       = 1;
  localparam int DEF_DELAY_W     = 25;

endpackage

// File: rtl/brick_row_if.sv
// Signal bundle between the game logic and the brick row.
//   master : drives ball_x/ball_y, init_x/init_y, delay_done;
//            observes x0, y, exist, hit, hit_idx, game_over, cleared
//   slave  : the brick row itself (opposite directions)
interface brick_row_if
  import brick_pkg::*;
#(
  parameter int N_BRICKS = DEF_N_BRICKS,
  parameter int COORD_W  = DEF_COORD_W,
  parameter int DELAY_W  = DEF_DELAY_W
);
  localparam int IDX_W = (N_BRICKS > 1) ? $clog2(N_BRICKS) : 1;

  logic [COORD_W-1:0]  ball_x;
  logic [COORD_W-1:0]  ball_y;
  logic [COORD_W-1:0]  init_x;
  logic [COORD_W-1:0]  init_y;
  logic [DELAY_W-1:0]  delay_done;
  logic [COORD_W-1:0]  x0;
  logic [COORD_W-1:0]  y;
  logic [N_BRICKS-1:0] exist;
  logic                hit;
  logic [IDX_W-1:0]    hit_idx;
  logic                game_over;
  logic                cleared;

  modport master (
    output ball_x, ball_y, init_x, init_y, delay_done,
    input  x0, y, exist, hit, hit_idx, game_over, cleared
  );

  modport slave (
    input  ball_x, ball_y, init_x, init_y, delay_done,
    output x0, y, exist, hit, hit_idx, game_over, cleared
  );

endinterface

// File: rtl/brick_hit_detect.sv
// Combinational rectangle-overlap test between the ball and one brick.
//   ball_x, ball_y   : ball origin (already widened by the caller)
//   brick_x, brick_y : brick origin
//   alive            : brick still present
//   overlap          : alive and the two rectangles touch or intersect
module brick_hit_detect #(
  parameter int CW        = 11,
  parameter int BRICK_W   = 57,
  parameter int BRICK_H   = 19,
  parameter int BALL_SIZE = 20
) (
  input  logic [CW-1:0] ball_x,
  input  logic [CW-1:0] ball_y,
  input  logic [CW-1:0] brick_x,
  input  logic [CW-1:0] brick_y,
  input  logic          alive,
  output logic          overlap
);

  always_comb begin
    overlap = alive
           && (ball_x <= brick_x + CW'(BRICK_W))
           && (ball_x + CW'(BALL_SIZE) >= brick_x)
           && (ball_y <= brick_y + CW'(BRICK_H))
           && (ball_y + CW'(BALL_SIZE) >= brick_y);
  end

endmodule

// File: rtl/brick_row.sv
// Descending row of breakable bricks.
//   clk, rst : clock and synchronous active-high reset
//   bus      : brick_row_if slave -- ball position, reset-time origin,
//              descent delay in; row origin/y, alive mask, hit pulse with
//              index, sticky game_over and cleared out
// The controller cycles CHECK (latch overlap mask) -> RESOLVE (destroy the
// lowest overlapping brick) -> MOVE (descend when the delay has elapsed)
// and parks in DONE once the row is cleared or reaches the floor.
module brick_row
  import brick_pkg::*;
#(
  parameter int N_BRICKS    = DEF_N_BRICKS,
  parameter int COORD_W     = DEF_COORD_W,
  parameter int BRICK_W     = DEF_BRICK_W,
  parameter int BRICK_H     = DEF_BRICK_H,
  parameter int BRICK_PITCH = DEF_BRICK_PITCH,
  parameter int BALL_SIZE   = DEF_BALL_SIZE,
  parameter int FLOOR_Y     = DEF_FLOOR_Y,
  parameter int SPEED       = DEF_SPEED,
  parameter int DELAY_W     = DEF_DELAY_W
) (
  input logic        clk,
  input logic        rst,
  brick_row_if.slave bus
);

  localparam int IDX_W = (N_BRICKS > 1) ? $clog2(N_BRICKS) : 1;
  // One extra bit so that origin + extent never wraps into a false hit.
  localparam int CW = COORD_W + 1;

  state_t state_q, state_nx;

  logic [COORD_W-1:0]  x0_q;
  logic [COORD_W-1:0]  y_q;
  logic [N_BRICKS-1:0] exist_q;
  logic [N_BRICKS-1:0] mask_q;
  logic [DELAY_W-1:0]  delay_q;
  logic                hit_q;
  logic [IDX_W-1:0]    hit_idx_q;
  logic                game_over_q;
  logic                cleared_q;

  logic [N_BRICKS-1:0] overlap;
  logic [N_BRICKS-1:0] clr_onehot;
  logic [N_BRICKS-1:0] exist_after;
  logic [IDX_W-1:0]    lo_idx;
  logic                lo_found;
  logic                hit_now;
  logic                clear_set;
  logic                go_set;
  logic                delay_hit;
  logic                step;
  logic [CW-1:0]       y_sum;
  logic [COORD_W-1:0]  y_inc;

  for (genvar i = 0; i < N_BRICKS; i++) begin : g_brick
    logic [CW-1:0] brick_x;
    assign brick_x = {1'b0, x0_q} + CW'(i * BRICK_PITCH);

    brick_hit_detect #(
      .CW        (CW),
      .BRICK_W   (BRICK_W),
      .BRICK_H   (BRICK_H),
      .BALL_SIZE (BALL_SIZE)
    ) u_detect (
      .ball_x  ({1'b0, bus.ball_x}),
      .ball_y  ({1'b0, bus.ball_y}),
      .brick_x (brick_x),
      .brick_y ({1'b0, y_q}),
      .alive   (exist_q[i]),
      .overlap (overlap[i])
    );
  end

  always_comb begin
    lo_found   = 1'b0;
    lo_idx     = '0;
    clr_onehot = '0;
    for (int unsigned i = 0; i < N_BRICKS; i++) begin
      if (!lo_found && mask_q[i]) begin
        lo_found      = 1'b1;
        lo_idx        = IDX_W'(i);
        clr_onehot[i] = 1'b1;
      end
    end

    hit_now     = (state_q == RESOLVE) && lo_found;
    exist_after = exist_q & ~clr_onehot;
    clear_set   = hit_now && (exist_after == '0);
    // Clearing the last brick wins over reaching the floor in the same cycle.
    go_set      = (state_q != DONE) && !clear_set && (exist_q != '0)
               && ({1'b0, y_q} >= CW'(FLOOR_Y));
    delay_hit   = (delay_q >= bus.delay_done);
    step        = (state_q == MOVE) && delay_hit && !go_set;

    y_sum = {1'b0, y_q} + CW'(SPEED);
    y_inc = y_sum[COORD_W] ? '1 : y_sum[COORD_W-1:0];

    state_nx = state_q;
    case (state_q)
      CHECK:   state_nx = RESOLVE;
      RESOLVE: state_nx = MOVE;
      MOVE:    state_nx = CHECK;
      default: state_nx = DONE;
    endcase
    if (clear_set || go_set) state_nx = DONE;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= CHECK;
    else     state_q <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x0_q        <= bus.init_x;
      y_q         <= bus.init_y;
      exist_q     <= '1;
      mask_q      <= '0;
      delay_q     <= '0;
      hit_q       <= 1'b0;
      hit_idx_q   <= '0;
      game_over_q <= 1'b0;
      cleared_q   <= 1'b0;
    end else begin
      hit_q <= hit_now;
      if (hit_now) begin
        exist_q   <= exist_after;
        hit_idx_q <= lo_idx;
      end
      if (state_q == CHECK) mask_q <= overlap;
      if (clear_set) cleared_q   <= 1'b1;
      if (go_set)    game_over_q <= 1'b1;
      if (step)      y_q         <= y_inc;

      if (state_nx == DONE)                  delay_q <= '0;
      else if (state_q == MOVE && delay_hit) delay_q <= '0;
      else if (delay_q != '1)                delay_q <= delay_q + DELAY_W'(1);
    end
  end

  assign bus.x0        = x0_q;
  assign bus.y         = y_q;
  assign bus.exist     = exist_q;
  assign bus.hit       = hit_q;
  assign bus.hit_idx   = hit_idx_q;
  assign bus.game_over = game_over_q;
  assign bus.cleared   = cleared_q;

endmodule

// File: tb/tb_brick_row.sv
// Self-checking bench for brick_row: directed vector table, hand-written
// multi-cycle sequences, and a randomized run against a behavioural model.
module tb_brick_row;
  import brick_pkg::*;

  localparam int DMAX = 2**25 - 1;

  logic clk = 1'b0;
  logic rst  = 1'b1;
  logic rst2 = 1'b1;

  always #5 clk = ~clk;

  brick_row_if #(.N_BRICKS(8), .COORD_W(10), .DELAY_W(25)) bus ();
  brick_row_if #(.N_BRICKS(2), .COORD_W(10), .DELAY_W(25)) bus2 ();

  brick_row #(.N_BRICKS(8)) dut  (.clk(clk), .rst(rst),  .bus(bus));
  brick_row #(.N_BRICKS(2)) dut2 (.clk(clk), .rst(rst2), .bus(bus2));

  int checks   = 0;
  int failures = 0;

  int cur_ix, cur_iy, cur_bx, cur_by, cur_dd;

  // behavioural model state
  int       m_phase, m_y, m_x0, m_delay, m_idx;
  bit       m_hit, m_go, m_cl;
  bit [7:0] m_exist, m_mask;

  typedef struct {
    int ix, iy, bx, by, dd, cyc;
    int exp_exist, exp_y, exp_hits, exp_idx, exp_go, exp_cl;
  } vec_t;

  vec_t vt[13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic set_in(input int ix, input int iy, input int bx, input int by, input int dd);
    cur_ix = ix; cur_iy = iy; cur_bx = bx; cur_by = by; cur_dd = dd;
    bus.init_x     = 10'(ix);
    bus.init_y     = 10'(iy);
    bus.ball_x     = 10'(bx);
    bus.ball_y     = 10'(by);
    bus.delay_done = 25'(dd);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  function automatic bit model_overlap(input int i);
    int xi;
    xi = m_x0 + 64 * i;
    return (cur_bx <= xi + 57) && (cur_bx + 20 >= xi)
        && (cur_by <= m_y + 19) && (cur_by + 20 >= m_y);
  endfunction

  // Game rules evaluated once per clock: phase 0..2 is the scan/resolve/move
  // pass, phase 3 means the game has ended.
  task automatic model_edge(input bit r);
    int nph, ny, nd, nidx;
    bit nhit, ncl, ngo;
    bit [7:0] nex, nmask;
    if (r) begin
      m_phase = 0; m_exist = 8'hFF; m_x0 = cur_ix; m_y = cur_iy; m_delay = 0;
      m_hit = 0; m_idx = 0; m_go = 0; m_cl = 0; m_mask = 0;
      return;
    end
    if (m_phase == 3) begin
      m_hit = 0; m_delay = 0;
      return;
    end
    nhit = 0; nex = m_exist; nidx = m_idx; nmask = m_mask; ncl = 0; ngo = 0;
    if (m_phase == 1)
      for (int i = 0; i < 8; i++)
        if (!nhit && m_mask[i]) begin nhit = 1; nidx = i; nex[i] = 1'b0; end
    if (nhit && nex == 8'h00) ncl = 1;
    if (!ncl && m_y >= 458 && m_exist != 8'h00) ngo = 1;
    if (m_phase == 0)
      for (int i = 0; i < 8; i++) nmask[i] = m_exist[i] && model_overlap(i);
    ny = m_y;
    nd = (m_delay < DMAX) ? m_delay + 1 : DMAX;
    if (m_phase == 2 && m_delay >= cur_dd) begin
      nd = 0;
      if (!ngo) ny = (m_y + 1 > 1023) ? 1023 : m_y + 1;
    end
    nph = (ncl || ngo) ? 3 : (m_phase + 1) % 3;
    if (nph == 3) nd = 0;
    m_phase = nph; m_y = ny; m_delay = nd; m_exist = nex; m_mask = nmask;
    m_hit = nhit; m_idx = nidx;
    m_go = m_go | ngo; m_cl = m_cl | ncl;
  endtask

  initial begin
    int hits, first;
    int hq[$];
    int iq[$];
    bit r;

    vt[0]  = '{10,   0,   600, 400, 2000, 1000, 'hFF, 0,   0, 0, 0, 0};
    vt[1]  = '{10,   0,   140, 5,   2000, 10,   'hFB, 0,   1, 2, 0, 0};
    vt[2]  = '{10,   0,   60,  5,   2000, 10,   'hFC, 0,   2, 0, 0, 0};
    vt[3]  = '{10,   455, 600, 50,  0,    30,   'hFF, 458, 0, 0, 1, 0};
    vt[4]  = '{10,   0,   600, 400, 5,    60,   'hFF, 10,  0, 0, 0, 0};
    vt[5]  = '{10,   458, 600, 100, 2000, 3,    'hFF, 458, 0, 0, 1, 0};
    vt[6]  = '{10,   0,   68,  19,  2000, 10,   'hFD, 0,   1, 1, 0, 0};
    vt[7]  = '{30,   0,   10,  5,   2000, 10,   'hFE, 0,   1, 0, 0, 0};
    vt[8]  = '{10,   0,   140, 20,  2000, 10,   'hFF, 0,   0, 0, 0, 0};
    vt[9]  = '{10,   100, 140, 80,  2000, 10,   'hFB, 100, 1, 2, 0, 0};
    vt[10] = '{10,   100, 140, 79,  2000, 10,   'hFF, 100, 0, 0, 0, 0};
    vt[11] = '{1000, 0,   1010, 5,  2000, 10,   'hFE, 0,   1, 0, 0, 0};
    vt[12] = '{1000, 0,   40,  5,   2000, 10,   'hFF, 0,   0, 0, 0, 0};

    bus2.init_x = 10'd10; bus2.init_y = 10'd0;
    bus2.ball_x = 10'd60; bus2.ball_y = 10'd5; bus2.delay_done = 25'd0;

    // ---------------- table-driven vectors ----------------
    for (int v = 0; v < 13; v++) begin
      set_in(vt[v].ix, vt[v].iy, vt[v].bx, vt[v].by, vt[v].dd);
      do_reset();
      chk($sformatf("v%0d_rst_exist", v), bus.exist, 64'hFF);
      chk($sformatf("v%0d_rst_y", v), bus.y, vt[v].iy);
      chk($sformatf("v%0d_rst_x0", v), bus.x0, vt[v].ix);
      chk($sformatf("v%0d_rst_flags", v), {bus.hit, bus.game_over, bus.cleared}, 0);
      hits = 0; first = -1;
      for (int c = 0; c < vt[v].cyc; c++) begin
        @(posedge clk); #1;
        if (bus.hit === 1'b1) begin
          if (hits == 0) first = int'(bus.hit_idx);
          hits++;
        end
      end
      chk($sformatf("v%0d_exist", v), bus.exist, vt[v].exp_exist);
      chk($sformatf("v%0d_y", v), bus.y, vt[v].exp_y);
      chk($sformatf("v%0d_hits", v), hits, vt[v].exp_hits);
      if (vt[v].exp_hits > 0) chk($sformatf("v%0d_first_idx", v), first, vt[v].exp_idx);
      chk($sformatf("v%0d_game_over", v), bus.game_over, vt[v].exp_go);
      chk($sformatf("v%0d_cleared", v), bus.cleared, vt[v].exp_cl);
    end

    // ---------------- two overlapping bricks: pulse spacing ----------------
    set_in(10, 0, 60, 5, 2000);
    do_reset();
    hq.delete(); iq.delete();
    for (int c = 0; c < 9; c++) begin
      @(posedge clk); #1;
      if (bus.hit === 1'b1) begin hq.push_back(c); iq.push_back(int'(bus.hit_idx)); end
    end
    chk("dbl_pulses", hq.size(), 2);
    if (hq.size() == 2) begin
      chk("dbl_first_cycle", hq[0], 1);
      chk("dbl_spacing", hq[1] - hq[0], 3);
      chk("dbl_idx0", iq[0], 0);
      chk("dbl_idx1", iq[1], 1);
    end

    // ---------------- reset from DONE ----------------
    set_in(10, 458, 600, 100, 2000);
    do_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("done_go", bus.game_over, 1);
    set_in(10, 20, 600, 100, 2000);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("done_rst_exist", bus.exist, 64'hFF);
    chk("done_rst_y", bus.y, 20);
    chk("done_rst_go", bus.game_over, 0);
    chk("done_rst_cl", bus.cleared, 0);
    rst = 1'b0;

    // ---------------- reset discards a pending hit ----------------
    set_in(10, 0, 140, 5, 2000);
    do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    set_in(10, 0, 600, 400, 2000);
    @(posedge clk); #1;
    chk("pend_hit", bus.hit, 0);
    rst = 1'b0;
    hits = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (bus.hit === 1'b1) hits++;
    end
    chk("pend_hits_after", hits, 0);
    chk("pend_exist", bus.exist, 64'hFF);

    // ---------------- two-brick row cleared ----------------
    rst2 = 1'b1;
    @(posedge clk); #1;
    rst2 = 1'b0;
    hits = 0;
    for (int c = 0; c < 16; c++) begin
      @(posedge clk); #1;
      if (bus2.hit === 1'b1) hits++;
    end
    chk("two_hits", hits, 2);
    chk("two_exist", bus2.exist, 0);
    chk("two_cleared", bus2.cleared, 1);
    chk("two_go", bus2.game_over, 0);
    chk("two_y_frozen", bus2.y, 1);

    // ---------------- randomized run vs model ----------------
    for (int c = 0; c < 3000; c++) begin
      r = (c == 0) || ($urandom_range(0, 149) == 0);
      if (r) begin
        cur_ix = $urandom_range(0, 560);
        cur_iy = $urandom_range(0, 460);
        cur_dd = $urandom_range(0, 7);
      end
      if (c % 4 == 0 || r) begin
        cur_bx = $urandom_range(0, 620);
        if ($urandom_range(0, 1) == 1) begin
          cur_by = (r ? cur_iy : m_y) + $urandom_range(0, 40) - 20;
          if (cur_by < 0) cur_by = 0;
        end else begin
          cur_by = $urandom_range(0, 500);
        end
      end
      set_in(cur_ix, cur_iy, cur_bx, cur_by, cur_dd);
      rst = r;
      @(posedge clk);
      model_edge(r);
      #1;
      chk("rnd_exist", bus.exist, m_exist);
      chk("rnd_y", bus.y, m_y);
      chk("rnd_x0", bus.x0, m_x0);
      chk("rnd_hit", bus.hit, m_hit);
      if (m_hit) chk("rnd_hit_idx", bus.hit_idx, m_idx);
      chk("rnd_game_over", bus.game_over, m_go);
      chk("rnd_cleared", bus.cleared, m_cl);
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
